shift_cmd_seq: RTL and testbench

// Command sequencer sitting directly upstream of the 4-bit universal shift register.

---
 rtl/shift_cmd_seq.sv | 118 +++++++++++
 tb/tb_shift_cmd_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_cmd_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// shift_cmd_seq : expands load/shift/rotate/hold commands into the per-cycle
//                 mode/din/lin/rin drive of a universal shift register.
// Revision 1.0
// ---------------------------------------------------------------------------
module shift_cmd_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic             cmd_fill,
  input  logic             cmd_rot,
  input  logic [WIDTH-1:0] sr_dout,
  output logic [1:0]       sr_mode,
  output logic [WIDTH-1:0] sr_din,
  output logic             sr_lin,
  output logic             sr_rin,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [1:0] OP_RIGHT = 2'b01;
  localparam logic [1:0] OP_LEFT  = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  localparam logic [WIDTH-1:0] LSB_MASK = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] cnt_q;
  logic             fill_q;
  logic             rot_q;
  logic             accept;

  assign accept = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      op_q   <= 2'b00;
      data_q <= '0;
      cnt_q  <= '0;
      fill_q <= 1'b0;
      rot_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
            cnt_q  <= cmd_cnt;
            fill_q <= cmd_fill;
            rot_q  <= cmd_rot;
            if (cmd_op == OP_LOAD)
              state <= LOAD;
            else if ((cmd_op == OP_RIGHT || cmd_op == OP_LEFT) && cmd_cnt != '0)
              state <= SHIFT;
            else
              state <= DONE;
          end
        end
        LOAD:  state <= DONE;
        SHIFT: begin
          if (cnt_q == CNT_W'(1))
            state <= DONE;
          else
            cnt_q <= cnt_q - CNT_W'(1);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are gated by reset so an abort silences the register drive at once.
  always_comb begin
    sr_mode   = 2'b00;
    sr_din    = '0;
    sr_lin    = 1'b0;
    sr_rin    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    cmd_ready = 1'b0;
    if (reset) begin
      busy      = (state != IDLE);
      cmd_ready = (state == IDLE);
      case (state)
        LOAD: begin
          sr_mode = OP_LOAD;
          sr_din  = data_q;
        end
        SHIFT: begin
          sr_mode = op_q;
          sr_lin  = rot_q ? |(sr_dout & LSB_MASK) : fill_q;
          sr_rin  = rot_q ? |(sr_dout & MSB_MASK) : fill_q;
        end
        DONE:    done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_cmd_seq.sv
`default_nettype none
// Self-checking bench for shift_cmd_seq with a behavioural shift register attached.
module tb_shift_cmd_seq;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_cnt;
  logic             cmd_fill;
  logic             cmd_rot;
  logic [WIDTH-1:0] sr_dout;
  logic [1:0]       sr_mode;
  logic [WIDTH-1:0] sr_din;
  logic             sr_lin;
  logic             sr_rin;
  logic             busy;
  logic             done;

  logic [3:0] sr_q = 4'd0;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_cmd_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt), .cmd_fill(cmd_fill),
    .cmd_rot(cmd_rot), .sr_dout(sr_dout), .sr_mode(sr_mode), .sr_din(sr_din),
    .sr_lin(sr_lin), .sr_rin(sr_rin), .busy(busy), .done(done)
  );

  // The universal shift register being driven
  assign sr_dout = sr_q;
  always @(posedge clk) begin
    case (sr_mode)
      2'b01:   sr_q <= {sr_lin, sr_q[3:1]};
      2'b10:   sr_q <= {sr_q[2:0], sr_rin};
      2'b11:   sr_q <= sr_din;
      default: ;
    endcase
  end

  typedef struct {
    logic [1:0] op;
    logic [3:0] data;
    logic [2:0] cnt;
    logic       fill;
    logic       rot;
    logic [3:0] init;
    logic [3:0] exp_final;
    int         exp_n;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] model_final(input logic [1:0] op, input logic [3:0] data,
                                             input int cnt, input logic fill, input logic rot,
                                             input logic [3:0] cur);
    int r;
    int in_bit;
    r = int'(cur);
    case (op)
      2'b11: r = int'(data);
      2'b01: for (int k = 0; k < cnt; k++) begin
        in_bit = rot ? (r & 1) : int'(fill);
        r = (r >> 1) | (in_bit << 3);
      end
      2'b10: for (int k = 0; k < cnt; k++) begin
        in_bit = rot ? ((r >> 3) & 1) : int'(fill);
        r = ((r << 1) & 15) | in_bit;
      end
      default: ;
    endcase
    return 4'(r);
  endfunction

  function automatic int model_steps(input logic [1:0] op, input int cnt);
    if (op == 2'b11) return 1;
    if (op == 2'b00) return 0;
    return cnt;
  endfunction

  task automatic scramble_inputs();
    cmd_op   = 2'($urandom_range(0, 3));
    cmd_data = 4'($urandom_range(0, 15));
    cmd_cnt  = 3'($urandom_range(0, 7));
    cmd_fill = 1'($urandom_range(0, 1));
    cmd_rot  = 1'($urandom_range(0, 1));
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [3:0] data, input logic [2:0] cnt,
                         input logic fill, input logic rot, input logic [3:0] exp_final,
                         input int exp_n, input string tag);
    int wait_c;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_cnt   = cnt;
    cmd_fill  = fill;
    cmd_rot   = rot;
    wait_c = 0;
    while (!cmd_ready && wait_c < 20) begin
      step();
      wait_c++;
    end
    if (!cmd_ready) begin
      chk({tag, " ready_timeout"}, 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    step();
    cmd_valid = 1'b0;
    scramble_inputs();
    for (int i = 0; i < exp_n; i++) begin
      chk({tag, " mode"}, 32'(sr_mode), 32'(op));
      chk({tag, " busy"}, 32'(busy), 32'd1);
      chk({tag, " ready_low"}, 32'(cmd_ready), 32'd0);
      chk({tag, " done_early"}, 32'(done), 32'd0);
      if (op == 2'b11) chk({tag, " din"}, 32'(sr_din), 32'(data));
      else             chk({tag, " din_zero"}, 32'(sr_din), 32'd0);
      if (op == 2'b01) chk({tag, " lin"}, 32'(sr_lin), 32'(rot ? sr_q[0] : fill));
      if (op == 2'b10) chk({tag, " rin"}, 32'(sr_rin), 32'(rot ? sr_q[3] : fill));
      step();
    end
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " done_mode"}, 32'(sr_mode), 32'd0);
    chk({tag, " done_ready"}, 32'(cmd_ready), 32'd0);
    chk({tag, " result"}, 32'(sr_q), 32'(exp_final));
    step();
    chk({tag, " done_pulse"}, 32'(done), 32'd0);
    chk({tag, " ready_again"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic preload(input logic [3:0] v);
    run_cmd(2'b11, v, 3'd0, 1'b0, 1'b0, v, 1, "preload");
  endtask

  initial begin
    logic [1:0] r_op;
    logic [3:0] r_data;
    logic [2:0] r_cnt;
    logic       r_fill;
    logic       r_rot;

    vecs[0] = '{op:2'b11, data:4'b1011, cnt:3'd0, fill:1'b0, rot:1'b0, init:4'b0000, exp_final:4'b1011, exp_n:1};
    vecs[1] = '{op:2'b10, data:4'b0000, cnt:3'd2, fill:1'b1, rot:1'b0, init:4'b0001, exp_final:4'b0111, exp_n:2};
    vecs[2] = '{op:2'b01, data:4'b0000, cnt:3'd3, fill:1'b0, rot:1'b1, init:4'b1000, exp_final:4'b0001, exp_n:3};
    vecs[3] = '{op:2'b01, data:4'b0000, cnt:3'd0, fill:1'b1, rot:1'b0, init:4'b0101, exp_final:4'b0101, exp_n:0};
    vecs[4] = '{op:2'b00, data:4'b1111, cnt:3'd5, fill:1'b1, rot:1'b0, init:4'b1100, exp_final:4'b1100, exp_n:0};
    vecs[5] = '{op:2'b10, data:4'b0000, cnt:3'd7, fill:1'b0, rot:1'b1, init:4'b1001, exp_final:4'b1100, exp_n:7};
    vecs[6] = '{op:2'b01, data:4'b0000, cnt:3'd3, fill:1'b0, rot:1'b0, init:4'b1111, exp_final:4'b0001, exp_n:3};

    // Reset held low with a pending load: nothing may be accepted
    reset     = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_data  = 4'hF;
    cmd_cnt   = 3'd0;
    cmd_fill  = 1'b0;
    cmd_rot   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst ready", 32'(cmd_ready), 32'd0);
      chk("rst mode", 32'(sr_mode), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
    end
    cmd_valid = 1'b0;
    reset     = 1'b1;
    step();
    chk("post_rst busy", 32'(busy), 32'd0);
    chk("post_rst ready", 32'(cmd_ready), 32'd1);
    chk("post_rst reg", 32'(sr_q), 32'd0);

    foreach (vecs[i]) begin
      preload(vecs[i].init);
      run_cmd(vecs[i].op, vecs[i].data, vecs[i].cnt, vecs[i].fill, vecs[i].rot,
              vecs[i].exp_final, vecs[i].exp_n, "vec");
    end

    // Abort: reset during the second step of a 5-step left shift
    preload(4'b0000);
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_cnt   = 3'd5;
    cmd_fill  = 1'b1;
    cmd_rot   = 1'b0;
    step();
    cmd_valid = 1'b0;
    chk("abort step1 mode", 32'(sr_mode), 32'd2);
    step();
    reset = 1'b0;
    #1;
    chk("abort mode", 32'(sr_mode), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("abort no_done", 32'(done), 32'd0);
      chk("abort no_mode", 32'(sr_mode), 32'd0);
      step();
    end
    chk("abort reg", 32'(sr_q), 32'b0001);
    chk("abort ready", 32'(cmd_ready), 32'd1);

    // Back-pressure: a command held during busy is taken in the first IDLE cycle
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_data  = 4'b1010;
    step();
    cmd_op = 2'b00;
    chk("bp load mode", 32'(sr_mode), 32'd3);
    chk("bp busy", 32'(busy), 32'd1);
    chk("bp ready_low", 32'(cmd_ready), 32'd0);
    step();
    chk("bp done1", 32'(done), 32'd1);
    chk("bp ready_in_done", 32'(cmd_ready), 32'd0);
    step();
    chk("bp idle ready", 32'(cmd_ready), 32'd1);
    chk("bp idle busy", 32'(busy), 32'd0);
    step();
    cmd_valid = 1'b0;
    chk("bp done2", 32'(done), 32'd1);
    chk("bp hold mode", 32'(sr_mode), 32'd0);
    step();
    chk("bp done2_pulse", 32'(done), 32'd0);
    chk("bp reg", 32'(sr_q), 32'b1010);

    // Randomized commands against the reference model
    for (int t = 0; t < 40; t++) begin
      cmd_valid = 1'b0;
      repeat ($urandom_range(0, 2)) step();
      r_op   = 2'($urandom_range(0, 3));
      r_data = 4'($urandom_range(0, 15));
      r_cnt  = 3'($urandom_range(0, 7));
      r_fill = 1'($urandom_range(0, 1));
      r_rot  = 1'($urandom_range(0, 1));
      run_cmd(r_op, r_data, r_cnt, r_fill, r_rot,
              model_final(r_op, r_data, int'(r_cnt), r_fill, r_rot, sr_q),
              model_steps(r_op, int'(r_cnt)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
